// File: rtl/instr_encoder.sv
// instr_encoder: two-stage streaming RV32I instruction encoder.
// Stage 1 registers the input fields and classifies the instruction format.
// Stage 2 packs the 32-bit word, checks that the immediate fits, and tags it
// with the instruction-memory write address for the boot/debug injector.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [6:0]        Opcode,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [2:0]        Funct3,
  input  logic [6:0]        Funct7,
  input  logic [31:0]       Imm,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] WrAddr,
  output logic              EncError,
  output logic              ErrSticky
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              r_v1;
  logic [6:0]        r_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [2:0]        r_f3;
  logic [6:0]        r_f7;
  logic [31:0]       r_imm;
  logic [2:0]        r_fmt;

  logic              r_v2;
  logic [31:0]       r_instr;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sticky;

  logic              w_adv1;
  logic              w_adv2;
  logic [2:0]        w_fmt;
  logic [31:0]       w_word;
  logic              w_bad;
  logic              w_fitsI;
  logic              w_fitsB;
  logic              w_fitsJ;

  // The output stage frees up when empty or drained; stage 1 frees when empty or moving on.
  assign w_adv2  = !r_v2 || OutReady;
  assign w_adv1  = !r_v1 || w_adv2;
  assign InReady = w_adv1 && !Flush && rst_n;

  // Classify the instruction format from the major opcode; shifts are I-type with a shamt.
  always_comb begin
    w_fmt = FMT_ILL;
    if (Opcode[1:0] == 2'b11) begin
      case (Opcode[6:2])
        5'd8:                       w_fmt = FMT_S;
        5'd24:                      w_fmt = FMT_B;
        5'd5, 5'd13:                w_fmt = FMT_U;
        5'd27:                      w_fmt = FMT_J;
        5'd0, 5'd3, 5'd25, 5'd28:   w_fmt = FMT_I;
        5'd4:                       w_fmt = (Funct3[1:0] == 2'b01) ? FMT_SH : FMT_I;
        5'd12, 5'd14:               w_fmt = FMT_R;
        default:                    w_fmt = FMT_ILL;
      endcase
    end
  end

  // Stage 1: capture the fields of each accepted item together with its format.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_op  <= '0;
      r_rd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_f3  <= '0;
      r_f7  <= '0;
      r_imm <= '0;
      r_fmt <= FMT_ILL;
    end else if (Flush) begin
      r_v1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= InValid;
      if (InValid) begin
        r_op  <= Opcode;
        r_rd  <= Rd;
        r_rs1 <= Rs1;
        r_rs2 <= Rs2;
        r_f3  <= Funct3;
        r_f7  <= Funct7;
        r_imm <= Imm;
        r_fmt <= w_fmt;
      end
    end
  end

  // An immediate fits when all bits above its top encoded bit are copies of the sign.
  assign w_fitsI = (&r_imm[31:11]) || !(|r_imm[31:11]);
  assign w_fitsB = (&r_imm[31:12]) || !(|r_imm[31:12]);
  assign w_fitsJ = (&r_imm[31:20]) || !(|r_imm[31:20]);

  // Assemble the word for the stage-1 item; anything that does not encode becomes a NOP.
  always_comb begin
    w_word = NOP;
    w_bad  = 1'b1;
    case (r_fmt)
      FMT_R: begin
        w_word = {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_op};
        w_bad  = 1'b0;
      end
      FMT_I: begin
        w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, r_op};
        w_bad  = !w_fitsI;
      end
      FMT_SH: begin
        w_word = {r_f7, r_imm[4:0], r_rs1, r_f3, r_rd, r_op};
        w_bad  = |r_imm[31:5];
      end
      FMT_S: begin
        w_word = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_op};
        w_bad  = !w_fitsI;
      end
      FMT_B: begin
        w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3, r_imm[4:1], r_imm[11], r_op};
        w_bad  = !w_fitsB || r_imm[0];
      end
      FMT_U: begin
        w_word = {r_imm[31:12], r_rd, r_op};
        w_bad  = |r_imm[11:0];
      end
      FMT_J: begin
        w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op};
        w_bad  = !w_fitsJ || r_imm[0];
      end
      default: begin
        w_word = NOP;
        w_bad  = 1'b1;
      end
    endcase
    if (w_bad) begin
      w_word = NOP;
    end
  end

  // Stage 2: output register, write address and sticky error, all restarted by Flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_instr  <= '0;
      r_err    <= 1'b0;
      r_addr   <= BASE_ADDR;
      r_sticky <= 1'b0;
    end else if (Flush) begin
      r_v2     <= 1'b0;
      r_addr   <= BASE_ADDR;
      r_sticky <= 1'b0;
    end else begin
      if (r_v2 && OutReady) begin
        r_addr <= r_addr + ADDR_W'(4);
        if (r_err) begin
          r_sticky <= 1'b1;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_instr <= w_word;
          r_err   <= w_bad;
        end
      end
    end
  end

  assign OutValid    = r_v2;
  assign Instruction = r_instr;
  assign WrAddr      = r_addr;
  assign EncError    = r_err;
  assign ErrSticky   = r_sticky;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: scenario tasks drive items and push the expected
// words into a scoreboard; a monitor pops and compares on each output handshake.
module tb_instr_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [6:0]  Opcode = '0;
  logic [4:0]  Rd = '0;
  logic [4:0]  Rs1 = '0;
  logic [4:0]  Rs2 = '0;
  logic [2:0]  Funct3 = '0;
  logic [6:0]  Funct7 = '0;
  logic [31:0] Imm = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] WrAddr;
  logic        EncError;
  logic        ErrSticky;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] modelAddr = BASE;
  logic        modelSticky = 1'b0;
  bit          randReady = 1'b0;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Funct7(Funct7),
    .Imm(Imm), .OutValid(OutValid), .OutReady(OutReady), .Instruction(Instruction),
    .WrAddr(WrAddr), .EncError(EncError), .ErrSticky(ErrSticky)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure, applied late in the cycle only while enabled.
  always @(posedge clk) begin
    #2;
    if (randReady) OutReady = 1'($urandom_range(0, 1));
  end

  // Reference encoder built from the field tables and integer immediate ranges.
  function automatic logic [32:0] modelEncode(input logic [6:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] imm);
    logic [31:0] w;
    logic        bad;
    int          s;
    s   = int'($signed(imm));
    w   = 32'h0;
    bad = 1'b0;
    if (op[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (op[6:2])
        5'd12, 5'd14: w = {f7, rs2, rs1, f3, rd, op};
        5'd0, 5'd3, 5'd4, 5'd25, 5'd28: begin
          if (op[6:2] == 5'd4 && (f3 == 3'b001 || f3 == 3'b101)) begin
            bad = (imm > 32'd31);
            w   = {f7, imm[4:0], rs1, f3, rd, op};
          end else begin
            bad = (s < -2048) || (s > 2047);
            w   = {imm[11:0], rs1, f3, rd, op};
          end
        end
        5'd8: begin
          bad = (s < -2048) || (s > 2047);
          w   = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        end
        5'd24: begin
          bad = (s < -4096) || (s > 4095) || imm[0];
          w   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        end
        5'd5, 5'd13: begin
          bad = ((imm & 32'h0000_0FFF) != 32'h0);
          w   = {imm[31:12], rd, op};
        end
        5'd27: begin
          bad = (s < -1048576) || (s > 1048575) || imm[0];
          w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) w = 32'h0000_0013;
    return {bad, w};
  endfunction

  // Scoreboard monitor: sticky tracking every cycle, in-order compare on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      modelAddr   = BASE;
      modelSticky = 1'b0;
    end else begin
      checks++;
      if (ErrSticky !== modelSticky) begin
        errors++;
        $display("[TB] FAIL sticky: ErrSticky=%b expected %b at cycle %0d", ErrSticky, modelSticky, cyc);
      end
      if (Flush) begin
        sb.delete();
        modelAddr   = BASE;
        modelSticky = 1'b0;
      end else if (OutValid === 1'b1 && OutReady === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output: Instruction=%h with empty scoreboard", Instruction);
        end else begin
          e = sb.pop_front();
          if (Instruction !== e.instr || EncError !== e.err || WrAddr !== modelAddr) begin
            errors++;
            $display("[TB] FAIL output: got instr=%h err=%b addr=%h, expected instr=%h err=%b addr=%h",
                     Instruction, EncError, WrAddr, e.instr, e.err, modelAddr);
          end
          if (e.lat != 0) begin
            checks++;
            if (cyc - e.acc != e.lat) begin
              errors++;
              $display("[TB] FAIL latency: got %0d cycles, expected %0d", cyc - e.acc, e.lat);
            end
          end
          if (e.err) modelSticky = 1'b1;
          modelAddr = modelAddr + 32'd4;
        end
      end
    end
  end

  // Present one item until accepted; push its expectation at the accepting cycle.
  task automatic sendItem(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm, input logic [31:0] expInstr,
                          input logic expErr, input int lat);
    bit   done;
    exp_t e;
    Opcode = op; Rd = rd; Rs1 = rs1; Rs2 = rs2; Funct3 = f3; Funct7 = f7; Imm = imm;
    InValid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (InReady === 1'b1 && !Flush && rst_n) begin
        e.instr = expInstr;
        e.err   = expErr;
        e.acc   = cyc;
        e.lat   = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    InValid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL accept_timeout: item op=%h imm=%h not accepted, InReady=%b", op, imm, InReady);
    end
  endtask

  task automatic sendModel(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm, input int lat);
    logic [32:0] m;
    m = modelEncode(op, rd, rs1, rs2, f3, f7, imm);
    sendItem(op, rd, rs1, rs2, f3, f7, imm, m[31:0], m[32], lat);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d items still expected", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulseFlush();
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    #12;
    checks++;
    if (OutValid !== 1'b0 || EncError !== 1'b0 || ErrSticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: OutValid=%b EncError=%b ErrSticky=%b, expected 0", OutValid, EncError, ErrSticky);
    end
    checks++;
    if (Instruction !== 32'h0 || WrAddr !== BASE) begin
      errors++;
      $display("[TB] FAIL reset_data: Instruction=%h WrAddr=%h, expected 0 and %h", Instruction, WrAddr, BASE);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_inready: InReady=%b expected 1", InReady);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    OutReady = 1'b1;
    sendItem(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h0050_0093, 1'b0, 2);
    sendItem(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020_A423, 1'b0, 2);
    sendItem(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 2);
    sendItem(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0, 2);
    waitDrain();
    checks++;
    if (WrAddr !== 32'd16) begin
      errors++;
      $display("[TB] FAIL b2b_addr: WrAddr=%h expected 00000010", WrAddr);
    end
  endtask

  task automatic test_enc_error();
    $display("[TB] test_enc_error");
    OutReady = 1'b1;
    sendItem(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1, 2);
    sendItem(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         32'h0000_0013, 1'b1, 2);
    waitDrain();
    checks++;
    if (ErrSticky !== 1'b1 || EncError !== 1'b1) begin
      errors++;
      $display("[TB] FAIL enc_error_flags: ErrSticky=%b EncError=%b, expected 1 and 1", ErrSticky, EncError);
    end
  endtask

  task automatic test_boundaries();
    $display("[TB] test_boundaries");
    OutReady = 1'b1;
    sendModel(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2047, 2);
    sendModel(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 2);
    sendModel(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF, 2);
    sendModel(7'h13, 5'd5, 5'd6, 5'd0, 3'd1, 7'h00, 32'd31, 2);
    sendModel(7'h13, 5'd5, 5'd6, 5'd0, 3'd1, 7'h00, 32'd32, 2);
    sendModel(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd5, 2);
    sendModel(7'h23, 5'd0, 5'd7, 5'd8, 3'd2, 7'd0, 32'hFFFF_F800, 2);
    sendModel(7'h23, 5'd0, 5'd7, 5'd8, 3'd0, 7'd0, 32'd2047, 2);
    sendModel(7'h63, 5'd0, 5'd9, 5'd10, 3'd1, 7'd0, 32'd4094, 2);
    sendModel(7'h63, 5'd0, 5'd9, 5'd10, 3'd1, 7'd0, 32'hFFFF_F000, 2);
    sendModel(7'h63, 5'd0, 5'd9, 5'd10, 3'd1, 7'd0, 32'd4096, 2);
    sendModel(7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574, 2);
    sendModel(7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 2);
    sendModel(7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576, 2);
    sendModel(7'h37, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 2);
    sendModel(7'h37, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 2);
    sendModel(7'h17, 5'd12, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 2);
    sendModel(7'h33, 5'd13, 5'd14, 5'd15, 3'd0, 7'h20, 32'hDEAD_BEEF, 2);
    sendModel(7'h3B, 5'd16, 5'd17, 5'd18, 3'd7, 7'h01, 32'd0, 2);
    sendModel(7'h12, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 2);
    sendModel(7'h0B, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 2);
    sendModel(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 2);
    waitDrain();
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    pulseFlush();
    OutReady = 1'b0;
    sendItem(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0193, 1'b0, 0);
    sendItem(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_0213, 1'b0, 0);
    fork
      sendItem(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0293, 1'b0, 0);
      begin
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (InReady !== 1'b0 || OutValid !== 1'b1 || Instruction !== 32'h0070_0193 || WrAddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL stall_hold: InReady=%b OutValid=%b Instruction=%h WrAddr=%h, expected 0 1 00700193 00000000",
                     InReady, OutValid, Instruction, WrAddr);
          end
        end
        @(posedge clk);
        #1;
        OutReady = 1'b1;
      end
    join
    waitDrain();
  endtask

  task automatic test_flush();
    $display("[TB] test_flush");
    OutReady = 1'b1;
    sendItem(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 32'h0000_0013, 1'b1, 2);
    waitDrain();
    checks++;
    if (ErrSticky !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_pre_sticky: ErrSticky=%b expected 1", ErrSticky);
    end
    OutReady = 1'b0;
    sendItem(7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0313, 1'b0, 0);
    sendItem(7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0393, 1'b0, 0);
    Flush = 1'b1;
    OutReady = 1'b1;
    Opcode = 7'h13; Rd = 5'd9; Rs1 = 5'd0; Imm = 32'd1;
    InValid = 1'b1;
    @(negedge clk);
    checks++;
    if (InReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_inready: InReady=%b expected 0", InReady);
    end
    @(posedge clk);
    #1;
    Flush = 1'b0;
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || ErrSticky !== 1'b0 || WrAddr !== BASE) begin
      errors++;
      $display("[TB] FAIL flush_clear: OutValid=%b ErrSticky=%b WrAddr=%h, expected 0 0 %h", OutValid, ErrSticky, WrAddr, BASE);
    end
    @(negedge clk);
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_stale: OutValid=%b expected 0", OutValid);
    end
    @(posedge clk);
    #1;
    sendItem(7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0413, 1'b0, 2);
    waitDrain();
    checks++;
    if (WrAddr !== BASE + 32'd4) begin
      errors++;
      $display("[TB] FAIL flush_addr: WrAddr=%h expected %h", WrAddr, BASE + 32'd4);
    end
  endtask

  function automatic logic [6:0] pickOp(input int k);
    case (k)
      0: return 7'h13;  1: return 7'h03;  2: return 7'h0F;  3: return 7'h67;
      4: return 7'h73;  5: return 7'h23;  6: return 7'h63;  7: return 7'h37;
      8: return 7'h17;  9: return 7'h6F; 10: return 7'h33; 11: return 7'h3B;
      12: return 7'h0B;
      default: return 7'h12;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] imm;
    int          t;
    $display("[TB] test_random");
    randReady = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: begin t = int'($urandom_range(0, 64)) - 32; imm = t; end
        1: imm = $urandom;
        2: imm = $urandom & 32'hFFFF_F000;
        default: begin t = int'($urandom_range(0, 8192)) - 4096; imm = t; end
      endcase
      sendModel(pickOp(int'($urandom_range(0, 13))), 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom), imm, 0);
    end
    randReady = 1'b0;
    OutReady = 1'b1;
    waitDrain();
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    OutReady = 1'b0;
    sendItem(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0, 0);
    sendItem(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (OutValid !== 1'b0 || Instruction !== 32'h0 || EncError !== 1'b0 || ErrSticky !== 1'b0 || WrAddr !== BASE || InReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: OutValid=%b Instruction=%h EncError=%b ErrSticky=%b WrAddr=%h InReady=%b, expected all reset",
               OutValid, Instruction, EncError, ErrSticky, WrAddr, InReady);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    OutReady = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (OutValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_stale: OutValid=%b Instruction=%h after reset release, expected 0", OutValid, Instruction);
      end
    end
    @(posedge clk);
    #1;
    sendItem(7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h0040_0493, 1'b0, 2);
    waitDrain();
    checks++;
    if (WrAddr !== BASE + 32'd4) begin
      errors++;
      $display("[TB] FAIL reset_addr: WrAddr=%h expected %h", WrAddr, BASE + 32'd4);
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_back_to_back();
    test_enc_error();
    test_boundaries();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder: inverse of the immediate generator. Packs opcode, register, funct and immediate fields into a 32-bit instruction word.
- Used by the debug/boot instruction injector to build words written into instruction memory.
- Two-stage valid/ready pipeline: full throughput, 2-cycle latency.
- Checks that each immediate is representable in its format. Tags each output with a memory write address.

Parameters:
- ADDR_W, 32, width of WrAddr.
- BASE_ADDR, 0, WrAddr value after reset/Flush.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- Flush  in  1  sync pipeline clear and address restart.
- InValid  in  1  input fields valid.
- InReady  out  1  encoder accepts fields this cycle.
- Opcode  in  7  instruction opcode field.
- Rd  in  5  destination register.
- Rs1  in  5  source register 1.
- Rs2  in  5  source register 2.
- Funct3  in  3  funct3 field.
- Funct7  in  7  funct7 field.
- Imm  in  32  signed byte-value immediate.
- OutValid  out  1  Instruction valid.
- OutReady  in  1  consumer accepts Instruction.
- Instruction  out  32  encoded word.
- WrAddr  out  ADDR_W  address for current Instruction.
- EncError  out  1  current output had an unrepresentable immediate or unknown opcode.
- ErrSticky  out  1  any EncError since reset/Flush.

Behaviour:
- Reset (async, rst_n=0): OutValid=0, Instruction=0, EncError=0, ErrSticky=0, WrAddr=BASE_ADDR. Internal stage valids=0. InReady=1 once rst_n=1.
- Stage 1 registers the fields and decodes format from Opcode[6:2]:
  - 8 -> S
  - 24 -> B
  - 5, 13 -> U
  - 27 -> J
  - 0, 3, 4, 25, 28 -> I
  - 12, 14 -> R
  - anything else -> illegal
  - Opcode[1:0]!=2'b11 -> illegal
- Stage 2 assembles the word and checks the immediate; result goes to the output register.
- Field placement: Rd[11:7], Funct3[14:12], Rs1[19:15], Rs2[24:20], Funct7[31:25], Opcode[6:0], only for formats that contain the field.
  - I: [31:20]=Imm[11:0].
  - S: [31:25]=Imm[11:5], [11:7]=Imm[4:0].
  - B: [31]=Imm[12], [30:25]=Imm[10:5], [11:8]=Imm[4:1], [7]=Imm[11].
  - U: [31:12]=Imm[31:12].
  - J: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12].
  - Shift (Opcode[6:2]=4, Funct3=001 or 101): [31:25]=Funct7, [24:20]=Imm[4:0].
- Range checks (violation -> EncError=1):
  - I, S: Imm[31:11] all equal.
  - Shift: Imm[31:5]=0.
  - B: Imm[31:12] all equal and Imm[0]=0.
  - J: Imm[31:20] all equal and Imm[0]=0.
  - U: Imm[11:0]=0.
  - R: Imm ignored.
  - Illegal opcode: always EncError=1.
- On EncError the item is still emitted, but Instruction=32'h00000013 (NOP). ErrSticky sets on the EncError output handshake.
- Handshake:
  - Stage 2 advances when !V2 || OutReady.
  - Stage 1 advances when !V1 || stage 2 advances.
  - InReady = that stage-1 advance condition, combinational from OutReady.
  - Input accepted on InValid&&InReady.
  - While OutValid=1 && OutReady=0, Instruction, WrAddr and EncError are held stable.
- WrAddr: increments by 4 after each OutValid&&OutReady; wraps modulo 2^ADDR_W.
- Latency: accept at edge N -> OutValid at edge N+2 when no backpressure; one item per cycle sustained.
- Flush (sync, dominant):
  - Clears both stage valids and OutValid; WrAddr=BASE_ADDR; ErrSticky=0.
  - Forces InReady=0 that cycle.
  - Same-cycle input or output handshakes are discarded: no WrAddr increment, no sticky update.
- Reset asserted mid-stream: all in-flight items are dropped immediately.

Test Plan:
- addi x1,x0,5 (Opcode 7'h13, Rd 1, F3 0, Rs1 0, Imm 5), OutReady=1 -> 2 cycles later Instruction=0x00500093, WrAddr=0, EncError=0.
- Back-to-back, following the addi above:
  - sw x2,8(x1) (7'h23, F3 2, Rs1 1, Rs2 2, Imm 8) -> 0x0020A423, WrAddr=4.
  - beq x0,x0,-4 (7'h63, Imm -4) -> 0xFE000EE3, WrAddr=8.
  - jal x1,2048 (7'h6F, Rd 1, Imm 0x800) -> 0x001000EF, WrAddr=12.
  - Expect one output per cycle.
- addi with Imm=0x800 -> Instruction=0x00000013, EncError=1, ErrSticky=1 after the handshake. A following beq with Imm=3 also gives EncError=1.
- OutReady=0 while sending 3 items -> InReady drops after 2 accepted, output holds item 0 stable. Release OutReady -> items emitted in order, WrAddr 0, 4, 8.
- Flush asserted with 2 items in flight and ErrSticky=1 -> next cycle OutValid=0, ErrSticky=0. The next accepted item emerges with WrAddr=BASE_ADDR.
- rst_n pulsed low mid-stream (asynchronous to clk) -> outputs go to reset values immediately; no stale output appears after release.
